// File: rtl/a2d_pkg.sv
// -----------------------------------------------------------------------------
// a2d_pkg
// Shared types and helpers for the round-robin ADC128S sequencer.
//   a2d_state_e  : top-level conversion FSM states
//   spi_phase_e  : phases of one 16-bit SPI transaction
//   CH_*         : A2D channel numbers of the three monitored inputs
//   rr_chan()    : round-robin pointer -> A2D channel
//   build_cmd()  : channel -> 16-bit command word (channel in bits 13:11)
// -----------------------------------------------------------------------------
package a2d_pkg;

  typedef enum logic [1:0] {IDLE, TX1, GAP, TX2} a2d_state_e;

  typedef enum logic [2:0] {PH_IDLE, PH_FRONT, PH_LOW, PH_HIGH, PH_BACK} spi_phase_e;

  localparam logic [2:0] CH_LFT  = 3'd0;
  localparam logic [2:0] CH_RGHT = 3'd4;
  localparam logic [2:0] CH_BATT = 3'd5;

  // Pointer value 3 is unreachable; it falls back to the left load cell.
  function automatic logic [2:0] rr_chan(input logic [1:0] ptr);
    case (ptr)
      2'd1:    rr_chan = CH_RGHT;
      2'd2:    rr_chan = CH_BATT;
      default: rr_chan = CH_LFT;
    endcase
  endfunction

  function automatic logic [15:0] build_cmd(input logic [2:0] ch);
    build_cmd = {2'b00, ch, 11'h000};
  endfunction

endpackage

// File: rtl/a2d_rr_sequencer_spi_mstr16.sv
// -----------------------------------------------------------------------------
// spi_mstr16
// 16-bit SPI master, SCLK idles high, MOSI changes on SCLK falling edges,
// MISO sampled on SCLK rising edges, MSB first.
//   clk, rst_n : clock, asynchronous active-low reset
//   wrt        : one-cycle request; cmd is latched and SS_n falls on the next edge
//   cmd[15:0]  : word to shift out
//   done       : one-cycle pulse, coincident with SS_n rising
//   rx[15:0]   : the 16 bits sampled from MISO (held until the next transaction)
//   SS_n, SCLK, MOSI (out), MISO (in) : SPI pins
// A transaction is a front porch of SCLK_DIV/2 cycles, 16 full SCLK periods
// (low half then high half) and a back porch of SCLK_DIV/2 cycles.
// -----------------------------------------------------------------------------
module spi_mstr16
  import a2d_pkg::*;
#(
  parameter int SCLK_DIV = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt,
  input  logic [15:0] cmd,
  output logic        done,
  output logic [15:0] rx,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  localparam int HALF = SCLK_DIV / 2;
  localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;

  spi_phase_e  phase_q;
  logic [HW-1:0] hc_q;
  logic [3:0]  bit_q;
  logic [15:0] tx_q;
  logic [15:0] rx_q;
  logic        ss_n_q;
  logic        sclk_q;
  logic        done_q;
  logic        half_end;

  assign half_end = (hc_q == HW'(HALF - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PH_IDLE;
      hc_q    <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      ss_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Half-period counter free-runs while a transaction is active.
      hc_q   <= (phase_q == PH_IDLE || half_end) ? '0 : hc_q + 1'b1;
      case (phase_q)
        PH_IDLE: begin
          if (wrt) begin
            ss_n_q  <= 1'b0;
            tx_q    <= cmd;  // bit 15 appears on MOSI as SS_n falls
            phase_q <= PH_FRONT;
          end
        end
        PH_FRONT: begin
          if (half_end) begin
            sclk_q  <= 1'b0;  // first falling edge: MSB already on MOSI
            bit_q   <= '0;
            phase_q <= PH_LOW;
          end
        end
        PH_LOW: begin
          if (half_end) begin
            sclk_q  <= 1'b1;
            rx_q    <= {rx_q[14:0], MISO};
            phase_q <= PH_HIGH;
          end
        end
        PH_HIGH: begin
          if (half_end) begin
            if (bit_q == 4'd15) begin
              phase_q <= PH_BACK;  // SCLK stays high after the last bit
            end else begin
              sclk_q  <= 1'b0;
              tx_q    <= {tx_q[14:0], 1'b0};
              bit_q   <= bit_q + 1'b1;
              phase_q <= PH_LOW;
            end
          end
        end
        PH_BACK: begin
          if (half_end) begin
            ss_n_q  <= 1'b1;
            done_q  <= 1'b1;
            tx_q    <= '0;
            phase_q <= PH_IDLE;
          end
        end
        default: phase_q <= PH_IDLE;
      endcase
    end
  end

  assign SS_n = ss_n_q;
  assign SCLK = sclk_q;
  assign MOSI = tx_q[15];
  assign done = done_q;
  assign rx   = rx_q;

endmodule

// File: rtl/a2d_rr_sequencer.sv
// -----------------------------------------------------------------------------
// a2d_rr_sequencer
// Runs one ADC128S conversion per strt_cnv on the next channel of the
// round-robin 0 (lft_ld), 4 (rght_ld), 5 (batt). A conversion is two SPI
// transactions carrying the same command; the second returns the result.
//   clk, rst_n        : clock, asynchronous active-low reset
//   strt_cnv          : start pulse, ignored while busy or during cnv_cmplt
//   MISO (in), SS_n, SCLK, MOSI (out) : SPI pins to the A2D
//   lft_ld, rght_ld, batt [11:0] : last result of channels 0, 4, 5
//   cnv_cmplt         : one-cycle pulse when a result register updates
//   busy              : high from the accepted start until cnv_cmplt
// -----------------------------------------------------------------------------
module a2d_rr_sequencer
  import a2d_pkg::*;
#(
  parameter int SCLK_DIV = 32,
  parameter int GAP_CYC  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        strt_cnv,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] batt,
  output logic        cnv_cmplt,
  output logic        busy
);

  localparam int GW = $clog2(GAP_CYC + 1);

  a2d_state_e    state_q;
  logic [1:0]    ptr_q;
  logic [2:0]    ch_q;
  logic [GW-1:0] gap_q;
  logic [11:0]   lft_q, rght_q, batt_q;
  logic          cmplt_q, busy_q;

  logic          accept, gap_end, spi_wrt, spi_done;
  logic [15:0]   spi_cmd, spi_rx;
  logic          unused_rx_hi;

  // A start landing in the cnv_cmplt cycle is dropped even though the FSM is
  // already back in IDLE.
  assign accept  = (state_q == IDLE) && strt_cnv && !cmplt_q;
  // The SPI master registers wrt, so launching at GAP_CYC-2 leaves SS_n high
  // for exactly GAP_CYC cycles between the two transactions.
  assign gap_end = (state_q == GAP) && (gap_q == GW'(GAP_CYC - 2));
  assign spi_wrt = accept || gap_end;
  assign spi_cmd = build_cmd((state_q == IDLE) ? rr_chan(ptr_q) : ch_q);
  assign unused_rx_hi = ^spi_rx[15:12];

  spi_mstr16 #(.SCLK_DIV(SCLK_DIV)) u_spi (
    .clk  (clk),
    .rst_n(rst_n),
    .wrt  (spi_wrt),
    .cmd  (spi_cmd),
    .done (spi_done),
    .rx   (spi_rx),
    .SS_n (SS_n),
    .SCLK (SCLK),
    .MOSI (MOSI),
    .MISO (MISO)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      ch_q    <= CH_LFT;
      gap_q   <= '0;
      lft_q   <= '0;
      rght_q  <= '0;
      batt_q  <= '0;
      cmplt_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      cmplt_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            ch_q    <= rr_chan(ptr_q);
            busy_q  <= 1'b1;
            state_q <= TX1;
          end
        end
        TX1: begin
          if (spi_done) begin
            gap_q   <= '0;
            state_q <= GAP;
          end
        end
        GAP: begin
          if (gap_end) state_q <= TX2;
          else         gap_q   <= gap_q + 1'b1;
        end
        TX2: begin
          if (spi_done) begin
            case (ptr_q)
              2'd0:    lft_q  <= spi_rx[11:0];
              2'd1:    rght_q <= spi_rx[11:0];
              default: batt_q <= spi_rx[11:0];
            endcase
            cmplt_q <= 1'b1;
            busy_q  <= 1'b0;
            ptr_q   <= (ptr_q == 2'd2) ? 2'd0 : ptr_q + 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign lft_ld    = lft_q;
  assign rght_ld   = rght_q;
  assign batt      = batt_q;
  assign cnv_cmplt = cmplt_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_a2d_rr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_a2d_rr_sequencer
// Bench for a2d_rr_sequencer with a behavioural ADC128S model: each SPI
// window answers with the value of the channel addressed in the previous
// window (random upper nibble), and records the MOSI word and SCLK count.
// Expected result registers come from a round-robin list model.
// -----------------------------------------------------------------------------
module tb_a2d_rr_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        strt_cnv = 1'b0;
  logic        MISO = 1'b0;
  logic        SS_n, SCLK, MOSI, cnv_cmplt, busy;
  logic [11:0] lft_ld, rght_ld, batt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  a2d_rr_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .strt_cnv (strt_cnv),
    .MISO     (MISO),
    .SS_n     (SS_n),
    .SCLK     (SCLK),
    .MOSI     (MOSI),
    .lft_ld   (lft_ld),
    .rght_ld  (rght_ld),
    .batt     (batt),
    .cnv_cmplt(cnv_cmplt),
    .busy     (busy)
  );

  // ---------------- ADC128S behavioural model ----------------
  logic [11:0] adc_val [8];
  logic [2:0]  ch_prev = 3'd0;
  logic [15:0] miso_word = 16'h0;
  logic [15:0] mosi_sh = 16'h0;
  logic [3:0]  nib;
  logic        ss_prev, sclk_prev;
  int          rises = 0;
  int          sclk_edges = 0;
  int          ch_warn = 0;
  logic [15:0] mosi_q [$];
  int          rise_q [$];

  always @(SS_n or SCLK) begin
    if (ss_prev === 1'b1 && SS_n === 1'b0) begin
      nib       = 4'($urandom_range(15));
      miso_word = {nib, adc_val[ch_prev]};
      rises     = 0;
      mosi_sh   = 16'h0;
      MISO      = miso_word[15];
    end else if (ss_prev === 1'b0 && SS_n === 1'b1) begin
      mosi_q.push_back(mosi_sh);
      rise_q.push_back(rises);
      if (rises == 16) begin
        if (!(mosi_sh[13:11] inside {3'd0, 3'd4, 3'd5}) || mosi_sh[15:14] != 2'b00)
          ch_warn++;
        ch_prev = mosi_sh[13:11];
      end
      MISO = 1'b0;
    end else if (SS_n === 1'b0 && sclk_prev === 1'b0 && SCLK === 1'b1) begin
      mosi_sh = {mosi_sh[14:0], MOSI};
      rises++;
    end else if (SS_n === 1'b0 && sclk_prev === 1'b1 && SCLK === 1'b0) begin
      if (rises < 16) MISO = miso_word[15 - rises];
    end
    if (sclk_prev !== SCLK) sclk_edges++;
    ss_prev   = SS_n;
    sclk_prev = SCLK;
  end

  // ---------------- reference model ----------------
  logic [2:0]  chan_of [3] = '{3'd0, 3'd4, 3'd5};
  logic [11:0] exp_regs [3] = '{12'h0, 12'h0, 12'h0};
  int          rr_idx = 0;

  function automatic logic [15:0] cmd_of(input logic [2:0] ch);
    return {2'b00, ch, 11'h000};
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic wait_cmplt(input int budget, inout int lat, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (cnv_cmplt === 1'b1) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_conv(output int lat, output bit to, output bit busy1);
    @(negedge clk);
    strt_cnv = 1'b1;
    @(negedge clk);
    strt_cnv = 1'b0;
    busy1 = busy;
    lat = 1;
    wait_cmplt(3000, lat, to);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int e0;
    repeat (3) @(negedge clk);
    checks++;
    if ({SS_n, SCLK, MOSI, busy, cnv_cmplt} !== 5'b11000) begin
      errors++;
      $display("FAIL reset_pins: {SS_n,SCLK,MOSI,busy,cmplt}=%b required 11000",
               {SS_n, SCLK, MOSI, busy, cnv_cmplt});
    end
    rst_n = 1'b1;
    e0 = sclk_edges;
    repeat (100) @(negedge clk);
    checks++;
    if ({SS_n, SCLK, busy} !== 3'b110 || sclk_edges != e0) begin
      errors++;
      $display("FAIL idle_100: SS_n=%b SCLK=%b busy=%b sclk_edges=%0d required 1 1 0 and 0 edges",
               SS_n, SCLK, busy, sclk_edges - e0);
    end
    checks++;
    if ({lft_ld, rght_ld, batt} !== 36'h0) begin
      errors++;
      $display("FAIL reset_regs: lft=%h rght=%h batt=%h required 000", lft_ld, rght_ld, batt);
    end
    $display("test_reset: done");
  endtask

  task automatic test_round_robin(input bit rnd, input int n);
    logic [11:0] tbl [4] = '{12'hC00, 12'hBF4, 12'hBE5, 12'hBD0};
    logic [2:0]  ch;
    logic [11:0] v;
    int          lat;
    bit          to, b1;
    for (int k = 0; k < n; k++) begin
      ch = chan_of[rr_idx];
      v  = rnd ? 12'($urandom_range(4095)) : tbl[k % 4];
      adc_val[ch] = v;
      mosi_q.delete();
      rise_q.delete();
      run_conv(lat, to, b1);
      checks++;
      if (to) begin
        errors++;
        $display("FAIL rr%0d_timeout: no cnv_cmplt in %0d cycles", k, lat);
      end
      checks++;
      if (lat < 1080 || lat > 1110) begin
        errors++;
        $display("FAIL rr%0d_latency: %0d cycles required 1080..1110", k, lat);
      end
      checks++;
      if (b1 !== 1'b1) begin
        errors++;
        $display("FAIL rr%0d_busy_rise: busy=%b after start required 1", k, b1);
      end
      checks++;
      if (mosi_q.size() != 2) begin
        errors++;
        $display("FAIL rr%0d_windows: %0d SS_n windows required 2", k, mosi_q.size());
      end else if (mosi_q[0] !== cmd_of(ch) || mosi_q[1] !== cmd_of(ch) ||
                   rise_q[0] != 16 || rise_q[1] != 16) begin
        errors++;
        $display("FAIL rr%0d_spi: mosi %h/%h rises %0d/%0d required %h/%h and 16/16",
                 k, mosi_q[0], mosi_q[1], rise_q[0], rise_q[1], cmd_of(ch), cmd_of(ch));
      end
      exp_regs[rr_idx] = v;
      rr_idx = (rr_idx + 1) % 3;
      checks++;
      if ({lft_ld, rght_ld, batt} !== {exp_regs[0], exp_regs[1], exp_regs[2]}) begin
        errors++;
        $display("FAIL rr%0d_regs: lft=%h rght=%h batt=%h required %h %h %h", k,
                 lft_ld, rght_ld, batt, exp_regs[0], exp_regs[1], exp_regs[2]);
      end
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL rr%0d_busy_fall: busy=%b at cnv_cmplt required 0", k, busy);
      end
      $display("conversion ch%0d value=%h latency=%0d", ch, v, lat);
    end
    checks++;
    if (ch_warn != 0) begin
      errors++;
      $display("FAIL channel_warn: %0d bad command words required 0", ch_warn);
    end
  endtask

  task automatic test_ignore_busy();
    logic [2:0]  ch;
    logic [11:0] v;
    int          lat;
    bit          to, b1;
    ch = chan_of[rr_idx];
    v  = 12'($urandom_range(4095));
    adc_val[ch] = v;
    mosi_q.delete();
    rise_q.delete();
    @(negedge clk);
    strt_cnv = 1'b1;
    @(negedge clk);
    strt_cnv = 1'b0;
    lat = 1;
    repeat (199) @(negedge clk);
    lat += 199;
    strt_cnv = 1'b1;
    @(negedge clk);
    strt_cnv = 1'b0;
    lat++;
    wait_cmplt(3000, lat, to);
    checks++;
    if (to || lat < 1080 || lat > 1110) begin
      errors++;
      $display("FAIL busy_start_latency: %0d cycles timeout=%b required 1080..1110", lat, to);
    end
    checks++;
    if (mosi_q.size() != 2) begin
      errors++;
      $display("FAIL busy_start_windows: %0d windows required 2", mosi_q.size());
    end
    exp_regs[rr_idx] = v;
    rr_idx = (rr_idx + 1) % 3;
    checks++;
    if ({lft_ld, rght_ld, batt} !== {exp_regs[0], exp_regs[1], exp_regs[2]}) begin
      errors++;
      $display("FAIL busy_start_regs: lft=%h rght=%h batt=%h required %h %h %h",
               lft_ld, rght_ld, batt, exp_regs[0], exp_regs[1], exp_regs[2]);
    end
    // Following conversion must take the next channel, with no queued extra one.
    repeat (50) @(negedge clk);
    checks++;
    if (SS_n !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_queued: SS_n=%b busy=%b after cmplt required 1 0", SS_n, busy);
    end
    ch = chan_of[rr_idx];
    v  = 12'($urandom_range(4095));
    adc_val[ch] = v;
    mosi_q.delete();
    rise_q.delete();
    run_conv(lat, to, b1);
    checks++;
    if (to || mosi_q.size() != 2 || mosi_q[0] !== cmd_of(ch)) begin
      errors++;
      $display("FAIL busy_next_channel: timeout=%b windows=%0d mosi=%h required cmd %h",
               to, mosi_q.size(), (mosi_q.size() > 0) ? mosi_q[0] : 16'hxxxx, cmd_of(ch));
    end
    exp_regs[rr_idx] = v;
    rr_idx = (rr_idx + 1) % 3;
    checks++;
    if ({lft_ld, rght_ld, batt} !== {exp_regs[0], exp_regs[1], exp_regs[2]}) begin
      errors++;
      $display("FAIL busy_next_regs: lft=%h rght=%h batt=%h required %h %h %h",
               lft_ld, rght_ld, batt, exp_regs[0], exp_regs[1], exp_regs[2]);
    end
    $display("test_ignore_busy: done");
  endtask

  task automatic test_reset_mid();
    logic [11:0] v;
    int          lat;
    bit          to, b1;
    adc_val[chan_of[rr_idx]] = 12'($urandom_range(4095));
    @(negedge clk);
    strt_cnv = 1'b1;
    @(negedge clk);
    strt_cnv = 1'b0;
    repeat (800) @(negedge clk);
    checks++;
    if (SS_n !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre: SS_n=%b busy=%b in TX2 required 0 1", SS_n, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({SS_n, SCLK, MOSI, busy, cnv_cmplt} !== 5'b11000) begin
      errors++;
      $display("FAIL reset_mid_pins: {SS_n,SCLK,MOSI,busy,cmplt}=%b required 11000",
               {SS_n, SCLK, MOSI, busy, cnv_cmplt});
    end
    checks++;
    if ({lft_ld, rght_ld, batt} !== 36'h0) begin
      errors++;
      $display("FAIL reset_mid_regs: lft=%h rght=%h batt=%h required 000", lft_ld, rght_ld, batt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_regs = '{12'h0, 12'h0, 12'h0};
    rr_idx = 0;
    v = 12'($urandom_range(4095));
    adc_val[0] = v;
    mosi_q.delete();
    rise_q.delete();
    run_conv(lat, to, b1);
    checks++;
    if (to || mosi_q.size() != 2 || mosi_q[0] !== 16'h0000 || mosi_q[1] !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid_restart: timeout=%b windows=%0d required ch0 words 0000",
               to, mosi_q.size());
    end
    exp_regs[0] = v;
    rr_idx = 1;
    checks++;
    if ({lft_ld, rght_ld, batt} !== {v, 24'h0}) begin
      errors++;
      $display("FAIL reset_mid_result: lft=%h rght=%h batt=%h required %h 000 000",
               lft_ld, rght_ld, batt, v);
    end
    $display("test_reset_mid: done");
  endtask

  task automatic test_cmplt_collision();
    logic [2:0]  ch;
    logic [11:0] v;
    int          lat;
    bit          to, b1;
    ch = chan_of[rr_idx];
    v  = 12'($urandom_range(4095));
    adc_val[ch] = v;
    run_conv(lat, to, b1);
    exp_regs[rr_idx] = v;
    rr_idx = (rr_idx + 1) % 3;
    checks++;
    if (to || {lft_ld, rght_ld, batt} !== {exp_regs[0], exp_regs[1], exp_regs[2]}) begin
      errors++;
      $display("FAIL collide_first: timeout=%b lft=%h rght=%h batt=%h required %h %h %h",
               to, lft_ld, rght_ld, batt, exp_regs[0], exp_regs[1], exp_regs[2]);
    end
    // Start asserted in the cnv_cmplt cycle, held into the following cycle.
    strt_cnv = 1'b1;
    ch = chan_of[rr_idx];
    v  = 12'($urandom_range(4095));
    adc_val[ch] = v;
    mosi_q.delete();
    rise_q.delete();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL collide_ignored: busy=%b after start in cmplt cycle required 0", busy);
    end
    @(negedge clk);
    strt_cnv = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL collide_next_accepted: busy=%b required 1", busy);
    end
    lat = 1;
    wait_cmplt(3000, lat, to);
    checks++;
    if (to || mosi_q.size() != 2 || mosi_q[0] !== cmd_of(ch)) begin
      errors++;
      $display("FAIL collide_channel: timeout=%b windows=%0d mosi=%h required %h",
               to, mosi_q.size(), (mosi_q.size() > 0) ? mosi_q[0] : 16'hxxxx, cmd_of(ch));
    end
    exp_regs[rr_idx] = v;
    rr_idx = (rr_idx + 1) % 3;
    checks++;
    if ({lft_ld, rght_ld, batt} !== {exp_regs[0], exp_regs[1], exp_regs[2]}) begin
      errors++;
      $display("FAIL collide_regs: lft=%h rght=%h batt=%h required %h %h %h",
               lft_ld, rght_ld, batt, exp_regs[0], exp_regs[1], exp_regs[2]);
    end
    $display("test_cmplt_collision: done");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in 50000 cycles");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8; i++) adc_val[i] = 12'h000;
    test_reset();
    test_round_robin(1'b0, 4);
    test_ignore_busy();
    test_reset_mid();
    test_cmplt_collision();
    test_round_robin(1'b1, 6);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
